// File: rtl/oci_debug_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oci_debug_port_arbiter
// Purpose  : Shares the CPU OCI register/memory port between the JTAG debug
//            slave and an Avalon-MM debug slave. Define
//            OCI_ARB_JTAG_PRIORITY_EN for fixed JTAG priority (else round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module oci_debug_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_req,
  input  logic              jtag_write,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_done,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_overrun,
  input  logic              jtag_ovr_clr,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int                 c_CNT_W       = 2;
  localparam logic [c_CNT_W-1:0] c_RD_CNT_INIT = c_CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                r_jtag_pending;
  logic                r_pend_wr;
  logic [ADDR_W-1:0]   r_pend_addr;
  logic [DATA_W-1:0]   r_pend_wdata;

  logic                r_owner_jtag;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_jtag_rdata;
  logic [DATA_W-1:0]   r_av_readdata;
  logic                r_jtag_overrun;

  logic                w_av_rq;
  logic                w_pick_jtag;
  logic                w_grant;
  logic                w_jtag_grant;

  assign w_av_rq = av_read | av_write;

`ifdef OCI_ARB_JTAG_PRIORITY_EN
  assign w_pick_jtag = r_jtag_pending;
`else
  logic r_last_jtag;

  // On a tie, serve whichever side did not get the previous grant.
  assign w_pick_jtag = r_jtag_pending & (~w_av_rq | ~r_last_jtag);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_jtag <= 1'b0;
    end else if (w_grant) begin
      r_last_jtag <= w_pick_jtag;
    end
  end
`endif

  assign w_grant      = (r_state == S_IDLE) & (r_jtag_pending | w_av_rq);
  assign w_jtag_grant = w_grant & w_pick_jtag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    mem_en         = 1'b0;
    mem_wr         = 1'b0;
    jtag_done      = 1'b0;
    av_waitrequest = 1'b1;
    busy           = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_grant) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en       = 1'b1;
        mem_wr       = r_wr;
        w_next_state = r_wr ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next_state = S_DONE;
      end
      S_DONE: begin
        jtag_done      = r_owner_jtag;
        av_waitrequest = r_owner_jtag;
        w_next_state   = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= '0;
      r_jtag_pending <= 1'b0;
      r_pend_wr      <= 1'b0;
      r_pend_addr    <= '0;
      r_pend_wdata   <= '0;
      r_owner_jtag   <= 1'b0;
      r_wr           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_jtag_rdata   <= '0;
      r_av_readdata  <= '0;
      r_jtag_overrun <= 1'b0;
    end else begin
      // A fresh strobe always wins over the grant clearing the pending flag.
      if (jtag_req) begin
        r_jtag_pending <= 1'b1;
        r_pend_wr      <= jtag_write;
        r_pend_addr    <= jtag_addr;
        r_pend_wdata   <= jtag_wdata;
      end else if (w_jtag_grant) begin
        r_jtag_pending <= 1'b0;
      end

      if (jtag_req && r_jtag_pending && !w_jtag_grant) begin
        r_jtag_overrun <= 1'b1;
      end else if (jtag_ovr_clr) begin
        r_jtag_overrun <= 1'b0;
      end

      if (w_grant) begin
        r_owner_jtag <= w_pick_jtag;
        r_wr         <= w_pick_jtag ? r_pend_wr    : av_write;
        r_addr       <= w_pick_jtag ? r_pend_addr  : av_address;
        r_wdata      <= w_pick_jtag ? r_pend_wdata : av_writedata;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= c_RD_CNT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
        if (r_cnt == '0) begin
          if (r_owner_jtag) r_jtag_rdata  <= mem_rdata;
          else              r_av_readdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign jtag_rdata   = r_jtag_rdata;
  assign av_readdata  = r_av_readdata;
  assign jtag_overrun = r_jtag_overrun;

endmodule
`default_nettype wire

// File: tb/tb_oci_debug_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oci_debug_port_arbiter
// Purpose  : Self-checking bench for oci_debug_port_arbiter with an OCI memory
//            responder and a transaction-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oci_debug_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              jtag_req, jtag_write, jtag_ovr_clr;
  logic [ADDR_W-1:0] jtag_addr;
  logic [DATA_W-1:0] jtag_wdata;
  logic              jtag_done, jtag_overrun;
  logic [DATA_W-1:0] jtag_rdata;
  logic              av_read, av_write, av_waitrequest;
  logic [ADDR_W-1:0] av_address;
  logic [DATA_W-1:0] av_writedata, av_readdata;
  logic              mem_en, mem_wr, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  oci_debug_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_req(jtag_req), .jtag_write(jtag_write), .jtag_addr(jtag_addr),
    .jtag_wdata(jtag_wdata), .jtag_done(jtag_done), .jtag_rdata(jtag_rdata),
    .jtag_overrun(jtag_overrun), .jtag_ovr_clr(jtag_ovr_clr),
    .av_read(av_read), .av_write(av_write), .av_address(av_address),
    .av_writedata(av_writedata), .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int tc = 0;

  always @(posedge clk) tc <= tc + 1;

  // OCI memory responder: read data is only valid exactly RD_LAT cycles after mem_en.
  logic [DATA_W-1:0] oci_mem [0:(1<<ADDR_W)-1];
  int                rd_due = -1;
  logic [DATA_W-1:0] rd_val;
  int                en_count = 0;
  int                en_cycle = -1;
  logic              en_wr;
  logic [ADDR_W-1:0] en_addr;
  logic [DATA_W-1:0] en_wdata;

  always @(negedge clk) begin
    mem_rdata <= (tc == rd_due) ? rd_val : $urandom;
    if (mem_en) begin
      en_count <= en_count + 1;
      en_cycle <= tc;
      en_wr    <= mem_wr;
      en_addr  <= mem_addr;
      en_wdata <= mem_wdata;
      if (mem_wr) oci_mem[mem_addr] <= mem_wdata;
      else begin
        rd_due <= tc + RD_LAT;
        rd_val <= oci_mem[mem_addr];
      end
    end
  end

  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  bit                model_last_jtag = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    chk("mem_en_implies_busy", {63'd0, (!mem_en || busy)}, 64'd1);
  endtask

  task automatic jtag_op(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n, base;
    bit seen;
    seen = 1'b0;
    base = en_count;
    n = tc;
    jtag_req = 1'b1; jtag_write = wr; jtag_addr = a; jtag_wdata = d;
    step();
    jtag_req = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (jtag_done) begin
        seen = 1'b1;
        chk("jtag_done_cycle", tc, wr ? n + 3 : n + 3 + RD_LAT);
        if (!wr) chk("jtag_rdata", jtag_rdata, shadow[a]);
      end else step();
    end
    chk("jtag_done_seen", seen, 1);
    chk("jtag_issue_cycle", en_cycle, n + 2);
    chk("jtag_issue_addr", en_addr, a);
    chk("jtag_issue_wr", en_wr, wr);
    if (wr) chk("jtag_issue_wdata", en_wdata, d);
    chk("jtag_one_access", en_count - base, 1);
    if (wr) shadow[a] = d;
    model_last_jtag = 1'b1;
    step();
    chk("jtag_idle_after", busy, 0);
  endtask

  task automatic av_op(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int m, base;
    bit seen;
    seen = 1'b0;
    base = en_count;
    m = tc;
    av_read = !wr; av_write = wr; av_address = a; av_writedata = d;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (!av_waitrequest) begin
        seen = 1'b1;
        chk("av_done_cycle", tc, wr ? m + 2 : m + 2 + RD_LAT);
        if (!wr) chk("av_readdata", av_readdata, shadow[a]);
      end
      step();
    end
    av_read = 1'b0; av_write = 1'b0;
    chk("av_done_seen", seen, 1);
    chk("av_issue_cycle", en_cycle, m + 1);
    chk("av_issue_addr", en_addr, a);
    chk("av_issue_wr", en_wr, wr);
    if (wr) chk("av_issue_wdata", en_wdata, d);
    chk("av_one_access", en_count - base, 1);
    if (wr) shadow[a] = d;
    model_last_jtag = 1'b0;
    chk("av_idle_after", busy, 0);
  endtask

  // JTAG write strobe at n, Avalon read from n+1: both contend in IDLE at n+1.
  task automatic pair_op(input logic [ADDR_W-1:0] ja, input logic [DATA_W-1:0] jd,
                         input logic [ADDR_W-1:0] aa);
    int n, jdc, adc;
    logic [DATA_W-1:0] ard;
    bit jfirst;
`ifdef OCI_ARB_JTAG_PRIORITY_EN
    jfirst = 1'b1;
`else
    jfirst = !model_last_jtag;
`endif
    jdc = -1; adc = -1; ard = '0;
    n = tc;
    jtag_req = 1'b1; jtag_write = 1'b1; jtag_addr = ja; jtag_wdata = jd;
    step();
    jtag_req = 1'b0;
    av_read = 1'b1; av_write = 1'b0; av_address = aa;
    for (int k = 0; k < 60 && (jdc < 0 || adc < 0); k++) begin
      if (jtag_done && jdc < 0) jdc = tc;
      if (!av_waitrequest && adc < 0) begin
        adc = tc;
        ard = av_readdata;
      end
      step();
      if (adc >= 0) av_read = 1'b0;
    end
    av_read = 1'b0;
    chk("pair_jtag_cycle", jdc, jfirst ? n + 3 : n + 6 + RD_LAT);
    chk("pair_av_cycle", adc, jfirst ? n + 6 + RD_LAT : n + 3 + RD_LAT);
    chk("pair_av_rdata", ard, shadow[aa]);
    shadow[ja] = jd;
    model_last_jtag = !jfirst;
  endtask

  initial begin
    int m, base, dones, gap;
    bit seen;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    reset_n = 1'b0;
    jtag_req = 1'b0; jtag_write = 1'b0; jtag_addr = '0; jtag_wdata = '0; jtag_ovr_clr = 1'b0;
    av_read = 1'b0; av_write = 1'b0; av_address = '0; av_writedata = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_jtag_done", jtag_done, 0);
    chk("rst_jtag_rdata", jtag_rdata, 0);
    chk("rst_av_readdata", av_readdata, 0);
    chk("rst_overrun", jtag_overrun, 0);
    chk("rst_waitrequest", av_waitrequest, 1);
    reset_n = 1'b1;
    step();

    jtag_op(1'b1, 9'h040, 32'hDEADBEEF);
    av_op(1'b1, 9'h100, 32'h12345678);
    av_op(1'b0, 9'h100, 32'h0);
    for (int i = 0; i < 16; i++) av_op(1'b1, 9'(i), $urandom);

    // Tie arbitration: first pair follows last grant, solo JTAG flips the next tie.
    pair_op(9'h003, 32'hC0DE0003, 9'h00A);
    jtag_op(1'b1, 9'h005, 32'hC0DE0005);
    pair_op(9'h006, 32'hC0DE0006, 9'h00B);

    // Two JTAG strobes while Avalon owns the port; second collides with ovr_clr.
    base = en_count; m = tc;
    av_read = 1'b1; av_address = 9'h100;
    step();
    jtag_req = 1'b1; jtag_write = 1'b1; jtag_addr = 9'h010; jtag_wdata = 32'hA5A50010;
    step();
    chk("ovr_after_first", jtag_overrun, 0);
    jtag_addr = 9'h020; jtag_wdata = 32'h5A5A0020; jtag_ovr_clr = 1'b1;
    step();
    jtag_req = 1'b0; jtag_ovr_clr = 1'b0;
    chk("ovr_set_wins", jtag_overrun, 1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (!av_waitrequest) begin
        seen = 1'b1;
        chk("ovr_av_cycle", tc, m + 2 + RD_LAT);
        chk("ovr_av_rdata", av_readdata, 32'h12345678);
      end
      step();
    end
    av_read = 1'b0;
    chk("ovr_av_seen", seen, 1);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      dones += int'(jtag_done);
      step();
    end
    chk("ovr_jtag_dones", dones, 1);
    chk("ovr_accesses", en_count - base, 2);
    chk("ovr_addr", en_addr, 9'h020);
    chk("ovr_wdata", en_wdata, 32'h5A5A0020);
    chk("ovr_sticky", jtag_overrun, 1);
    shadow[9'h020] = 32'h5A5A0020;
    model_last_jtag = 1'b1;
    jtag_ovr_clr = 1'b1;
    step();
    jtag_ovr_clr = 1'b0;
    chk("ovr_cleared", jtag_overrun, 0);

    // Reset in the middle of an Avalon read.
    av_read = 1'b1; av_address = 9'h100;
    step(); step();
    chk("mid_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_waitreq", av_waitrequest, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_av_readdata", av_readdata, 0);
    chk("mid_rst_jtag_rdata", jtag_rdata, 0);
    av_read = 1'b0;
    step();
    chk("mid_rst_hold_waitreq", av_waitrequest, 1);
    step();
    reset_n = 1'b1;
    model_last_jtag = 1'b0;
    step();
    jtag_op(1'b0, 9'h040, 32'h0);

    for (int i = 0; i < 40; i++) begin
      ra = 9'($urandom_range(0, 15));
      rd = $urandom;
      case ($urandom_range(0, 4))
        0: jtag_op(1'b1, ra, rd);
        1: jtag_op(1'b0, ra, rd);
        2: av_op(1'b1, ra, rd);
        3: av_op(1'b0, ra, rd);
        default: pair_op(9'($urandom_range(0, 7)), rd, 9'($urandom_range(8, 15)));
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oci_debug_port_arbiter.md
Name: oci_debug_port_arbiter

Overview:
- Shares the CPU's single on-chip-instrumentation (OCI) register/memory port between two requesters.
- Requester 1: the JTAG debug slave path. It issues single-cycle command strobes decoded from jdo.
- Requester 2: an Avalon-MM debug slave on the system interconnect.
- Sequences each access as a 4-state transaction with round-robin arbitration. Latches JTAG strobes so none is lost while the Avalon side owns the port.

Parameters:
ADDR_W, 9, OCI word address width
DATA_W, 32, data width
RD_LAT, 2, cycles from mem_en (read) to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jtag_req  in  1  single-cycle command strobe from debug slave sysclk domain
jtag_write  in  1  1=write, 0=read; qualified by jtag_req
jtag_addr  in  ADDR_W  address; qualified by jtag_req
jtag_wdata  in  DATA_W  write data; qualified by jtag_req
jtag_done  out  1  single-cycle completion pulse
jtag_rdata  out  DATA_W  read data; valid with jtag_done (read), held until next read completes
jtag_overrun  out  1  sticky: strobe arrived while previous one still pending
jtag_ovr_clr  in  1  clears jtag_overrun
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_address  in  ADDR_W  Avalon address
av_writedata  in  DATA_W  Avalon write data
av_waitrequest  out  1  Avalon waitrequest
av_readdata  out  DATA_W  valid in the cycle av_waitrequest=0 after a read
mem_en  out  1  OCI port access strobe, one cycle per transaction
mem_wr  out  1  write qualifier for mem_en
mem_addr  out  ADDR_W  OCI address
mem_wdata  out  DATA_W  OCI write data
mem_rdata  in  DATA_W  OCI read data, valid RD_LAT cycles after mem_en
busy  out  1  state != IDLE

Behaviour:
- Interface: single clock clk. Reset reset_n is asynchronous, active-low.
- Reset values: state=IDLE; jtag_pending=0; last_grant=AV; mem_en=0; mem_wr=0; mem_addr=0; mem_wdata=0; jtag_done=0; jtag_rdata=0; av_readdata=0; jtag_overrun=0; av_waitrequest=1; busy=0.
- JTAG capture:
  - jtag_req=1 sets jtag_pending and latches write/addr/wdata into pending registers.
  - jtag_pending clears on the cycle JTAG is granted.
  - jtag_req in the same cycle as the grant: the new command is latched, pending stays 1, no overrun.
  - jtag_req while pending=1 and not being granted: pending registers are overwritten (newest wins) and jtag_overrun is set.
  - jtag_ovr_clr clears jtag_overrun. If set and clear occur together, set wins.
- Avalon request: av_rq = av_read | av_write. The master holds its signals stable while waitrequest=1. Signals are sampled at grant.
- FSM:
  - IDLE: if jtag_pending or av_rq, grant and go to ISSUE. With both pending, grant the requester not equal to last_grant. Update last_grant.
  - ISSUE: mem_en=1 for exactly one cycle; mem_wr/addr/wdata from the granted request. Write goes to DONE; read goes to WAIT with cnt=RD_LAT-1.
  - WAIT: cnt decrements each cycle. When cnt==0, capture mem_rdata into jtag_rdata or av_readdata, then go to DONE.
  - DONE:
    - JTAG grant: jtag_done=1.
    - Avalon grant: av_waitrequest=0.
    - Next state IDLE.
- All outputs are registered or decoded only from registered state. av_waitrequest is 1 in every other cycle.
- Latency, JTAG strobe at cycle N with port idle:
  - mem_en at N+2.
  - Write: jtag_done at N+3.
  - Read: jtag_done at N+3+RD_LAT.
- Latency, Avalon request at cycle M with port idle:
  - Write: waitrequest low at M+2.
  - Read: waitrequest low at M+2+RD_LAT.
- Back-to-back: minimum 3 cycles per write transaction and 3+RD_LAT per read, because IDLE is always visited between transactions.
- Avalon request withdrawn before grant: no access, no error.
- Reset asserted mid-transaction: the transaction is abandoned immediately and all outputs take reset values. No jtag_done or waitrequest=0 is produced for it.
- mem_en never asserts outside ISSUE.

Optional Feature:
- Macro: OCI_ARB_JTAG_PRIORITY_EN.
- Defined: fixed priority. JTAG always wins a tie in IDLE, and last_grant is unused. This prevents Avalon traffic from stalling a debugger session.
- Undefined: round-robin as described above.

Test Plan:
- JTAG write, addr=0x040, data=0xDEADBEEF, port idle -> mem_en/mem_wr=1 at N+2 with those values; jtag_done at N+3; busy low at N+4.
- Avalon read, addr=0x100, mem_rdata model returns 0x12345678, RD_LAT=2 -> waitrequest high M..M+3, low at M+4 with av_readdata=0x12345678.
- jtag_req and av_read both assert from reset -> JTAG served first, Avalon next. Second simultaneous pair -> Avalon first (with OCI_ARB_JTAG_PRIORITY_EN: JTAG first both times).
- Two JTAG strobes during a long Avalon read (addr 0x010 then 0x020) -> jtag_overrun=1; one JTAG access, to 0x020; jtag_ovr_clr clears the flag.
- reset_n pulled low in WAIT of an Avalon read -> mem_en=0, av_waitrequest=1, busy=0 immediately. After release, a JTAG read completes normally.
